// File: rtl/operand_packer_pkg.sv
// Shared constants and slot encodings for the operand packer.
// Imported by the assembler top and its frame FIFO.
package operand_packer_pkg;

  localparam int N_DEF      = 10;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDX_A = 2'd0,
    IDX_B = 2'd1,
    IDX_C = 2'd2,
    IDX_D = 2'd3
  } idx_e;

endpackage

// File: rtl/operand_packer_frame_fifo.sv
// Two-entry frame FIFO holding assembled {A,B,C,D} words.
// Head is a plain register read; count drives the handshake flags.
module frame_fifo
  import operand_packer_pkg::*;
#(
  parameter int W = 4 * N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_push = push && (cnt_q != 2'(FIFO_DEPTH));
  assign do_pop  = pop && (cnt_q != 2'd0);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/operand_packer.sv
// Packs a serial word stream into {A,B,C,D} operand frames.
// in_ready comes only from FIFO occupancy, never from out_ready.
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic         in_ready,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err,
  output logic [7:0]   frame_cnt
);

  idx_e         idx_q, idx_d, slot;
  logic [1:0]   slot_nxt;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] c_q, c_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         accept;
  logic         push, pop;
  logic [4*N-1:0] head;
  logic [1:0]   fifo_cnt;

  assign in_ready  = (fifo_cnt != 2'(FIFO_DEPTH));
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign slot      = in_sof ? IDX_A : idx_q;
  assign slot_nxt  = slot + 2'd1;

  always_comb begin
    idx_d = idx_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    err_d = 1'b0;
    push  = 1'b0;
    cnt_d = pop ? cnt_q + 8'd1 : cnt_q;
    if (accept) begin
      unique case (1'b1)
        slot == IDX_A: a_d  = in_data;
        slot == IDX_B: b_d  = in_data;
        slot == IDX_C: c_d  = in_data;
        slot == IDX_D: push = 1'b1;
      endcase
      idx_d = idx_e'(slot_nxt);
      // sof mid-frame drops the partial words already held
      err_d = in_sof && (idx_q != IDX_A);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= IDX_A;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  frame_fifo #(
    .W(4 * N)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({a_q, b_q, c_q, in_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_cnt)
  );

  assign {A, B, C, D} = out_valid ? head : '0;
  assign frame_err    = err_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 Parameter: N, default 10, width of each operand and of the serial input word.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  N  serial operand word.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_sof  input  1  qualified by in_valid; marks the current word as operand A of a new frame.
REQ-007 Port: in_ready  output  1  block accepts a word this cycle.
REQ-008 Port: A, B, C, D  output  N each  operands of the head frame, feeding the downstream arithmetic pipeline.
REQ-009 Port: out_valid  output  1  A..D hold a complete frame.
REQ-010 Port: out_ready  input  1  downstream takes the frame this cycle; tie high for a free-running pipeline.
REQ-011 Port: frame_err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-012 Port: frame_cnt  output  8  count of frames delivered, modulo 256.

Function
REQ-013 Word accepted iff in_valid && in_ready at a rising edge; no other event changes the assembly state.
REQ-014 Assembly index idx (0..3) selects the destination slot: 0->A, 1->B, 2->C, 3->D; idx advances by 1 per accepted word and wraps 3->0.
REQ-015 On acceptance of the idx=3 word, the complete frame {A,B,C,D} is pushed into a 2-entry frame FIFO in the same edge.
REQ-016 Accepted word with in_sof=1: stored as A, idx becomes 1; if idx was nonzero, the partial frame is discarded and frame_err is high for exactly the following cycle.
REQ-017 Accepted word with in_sof=0 at idx=0: stored as A normally (in_sof is optional).
REQ-018 in_ready = !(FIFO count == 2); derived only from registered state, with no combinational path from out_ready or in_valid.
REQ-019 A pop in the same cycle as a full FIFO does not raise in_ready in that cycle; in_ready rises in the following cycle.
REQ-020 out_valid = (FIFO count != 0); A..D present the head entry; A..D = 0 whenever out_valid = 0.
REQ-021 Pop occurs iff out_valid && out_ready; frames leave in arrival order, with no loss or duplication.
REQ-022 Latency: if the 4th word is accepted at edge k with the FIFO empty, out_valid = 1 and A..D are valid in the cycle after edge k.
REQ-023 Simultaneous push and pop at count 1: count stays 1; the new frame becomes head after the edge.
REQ-024 While out_valid && !out_ready, A..D, out_valid and frame_cnt remain stable.
REQ-025 frame_cnt increments by 1 on each pop and wraps 255->0.

Reset
REQ-026 rst_n low asynchronously forces: idx=0, FIFO count=0, out_valid=0, A..D=0, in_ready=1, frame_err=0, frame_cnt=0.
REQ-027 Reset asserted mid-frame or with stored frames discards all partial and stored data; no stale frame appears after release.
REQ-028 First word may be accepted on the first rising edge with rst_n high.

Structure
REQ-029 Shared package holds: N default (10), FIFO depth (2), idx slot encodings (IDX_A..IDX_D).
REQ-030 One sub-module, frame_fifo: 2-entry, 4N-bit wide, with push/pop/count, same clk/rst_n; the assembler and flags stay in operand_packer.

Verification
REQ-031 Reset, out_ready=1, words 5(sof),10,15,20 -> out_valid=1 one cycle after 20 accepted, A=5 B=10 C=15 D=20, frame_cnt 0->1.
REQ-032 out_ready=0, send 4,8,12,16 then 3,6,9,12 then 6 -> in_ready=0 after the 2nd frame, word 6 stalls, A..D hold 4,8,12,16; raise out_ready -> frames 4..16 then 3..12 in order, then 6 accepted.
REQ-033 Send 6,12, then 8(sof),16,24,32 -> frame_err one-cycle pulse after the sof edge; only frame A=8 B=16 C=24 D=32 delivered.
REQ-034 One frame stored plus words 10,20 pending, pull rst_n low between edges -> out_valid=0, A..D=0, frame_cnt=0 immediately; after release, 9,18,27,36 -> exactly that frame delivered.
REQ-035 Random in_valid bubbles between words 10,20,30,40 -> frame A=10 B=20 C=30 D=40, unaffected by gaps.
REQ-036 256 consecutive frames with out_ready=1 -> frame_cnt returns to 0, no in_ready stall with push/pop at count 1.
